// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-4 DIF FFT pipeline (default N = 256).
// The state enum and tag type are used by the twiddle scheduler.
package fft_pkg;

    localparam int LOG2N   = 8;
    localparam int N       = 1 << LOG2N;
    localparam int NSTAGE  = LOG2N / 2;
    localparam int DW      = 22;
    localparam int MUL_LAT = 2;
    // address/data register + ROM read + multiplier
    localparam int TW_LAT  = 2 + MUL_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/twiddle_addr_gen.sv
// Combinational twiddle exponent for sample index j of radix-4 stage s.
// With TWSCHED_IFFT_EN defined an inv input selects the conjugate exponent (N - e) mod N.
module twiddle_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic [LOG2N-1:0]   j,
    input  logic [LOG2N/2-1:0] s,
`ifdef TWSCHED_IFFT_EN
    input  logic               inv,
`endif
    output logic [LOG2N-1:0]   e
);

    localparam int NSTG  = LOG2N / 2;
    localparam int STG_W = LOG2N / 2;
    localparam int KW    = LOG2N - 2;

    logic [LOG2N-1:0] e_stage [NSTG];
    logic [LOG2N-1:0] e_fwd;

    // Each stage has a fixed quarter-length Q = 2^QB, so m and k are plain bit fields of j.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        localparam int QB = LOG2N - 2 - 2 * gi;
        localparam logic [KW-1:0] KMASK = KW'((1 << QB) - 1);

        logic [1:0]       m;
        logic [KW-1:0]    k;
        logic [LOG2N-1:0] prod;

        assign m    = j[QB+1:QB];
        assign k    = j[KW-1:0] & KMASK;
        assign prod = {{KW{1'b0}}, m} * {2'b00, k};
        assign e_stage[gi] = prod << (2 * gi);
    end

    always_comb begin
        e_fwd = '0;
        for (int i = 0; i < NSTG; i++) begin
            if (s == STG_W'(i)) begin
                e_fwd = e_stage[i];
            end
        end
    end

`ifdef TWSCHED_IFFT_EN
    assign e = inv ? (~e_fwd + LOG2N'(1)) : e_fwd;
`else
    assign e = e_fwd;
`endif

endmodule

// File: rtl/twiddle_sched.sv
// Twiddle scheduler for one radix-4 DIF stage: counts butterfly samples, issues ROM
// addresses and carries valid/last tags across the multiplier. Optional TWSCHED_IFFT_EN adds inv.
module twiddle_sched
    import fft_pkg::*;
#(
    parameter int LOG2N   = fft_pkg::LOG2N,
    parameter int DW      = fft_pkg::DW,
    parameter int MUL_LAT = fft_pkg::MUL_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LOG2N/2-1:0] stage,
`ifdef TWSCHED_IFFT_EN
    input  logic               inv,
`endif
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               in_valid,
    input  logic [DW-1:0]      in_data,
    output logic [LOG2N-1:0]   tw_addr,
    output logic [DW-1:0]      tw_a,
    output logic               out_valid,
    output logic               out_last
);

    localparam int NSTG     = LOG2N / 2;
    localparam int STG_W    = LOG2N / 2;
    localparam int PIPE_LAT = 2 + MUL_LAT;

    sched_state_t     state_reg, state_next;
    logic [LOG2N-1:0] j_reg, j_next;
    logic [STG_W-1:0] s_reg, s_next;
    logic             err_reg, err_next;
    logic             accept, accept_last;
    logic [LOG2N-1:0] e_addr;
    tag_t             tag_sr_reg [PIPE_LAT];

`ifdef TWSCHED_IFFT_EN
    logic inv_reg, inv_next;
`endif

    twiddle_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .j   (j_reg),
        .s   (s_reg),
`ifdef TWSCHED_IFFT_EN
        .inv (inv_reg),
`endif
        .e   (e_addr)
    );

    always_comb begin
        state_next  = state_reg;
        j_next      = j_reg;
        s_next      = s_reg;
        err_next    = 1'b0;
        accept      = 1'b0;
        accept_last = 1'b0;
`ifdef TWSCHED_IFFT_EN
        inv_next    = inv_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (stage < STG_W'(NSTG)) begin
                        state_next = RUN;
                        s_next     = stage;
                        j_next     = '0;
`ifdef TWSCHED_IFFT_EN
                        inv_next   = inv;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
                // a sample arriving with no pass open is dropped, even alongside start
                if (in_valid) begin
                    err_next = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    err_next = 1'b1;
                end
                if (in_valid) begin
                    accept = 1'b1;
                    j_next = j_reg + LOG2N'(1);
                    if (j_reg == '1) begin
                        accept_last = 1'b1;
                        state_next  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (start || in_valid) begin
                    err_next = 1'b1;
                end
                if (tag_sr_reg[PIPE_LAT-1].valid && tag_sr_reg[PIPE_LAT-1].last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            j_reg     <= '0;
            s_reg     <= '0;
            err_reg   <= 1'b0;
            tw_addr   <= '0;
            tw_a      <= '0;
`ifdef TWSCHED_IFFT_EN
            inv_reg   <= 1'b0;
`endif
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_sr_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            j_reg     <= j_next;
            s_reg     <= s_next;
            err_reg   <= err_next;
`ifdef TWSCHED_IFFT_EN
            inv_reg   <= inv_next;
`endif
            // address and sample are registered together so tw_a lines up with ROM data
            if (accept) begin
                tw_addr <= e_addr;
                tw_a    <= in_data;
            end
            tag_sr_reg[0] <= '{valid: accept, last: accept_last};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_sr_reg[i] <= tag_sr_reg[i-1];
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign err       = err_reg;
    assign out_valid = tag_sr_reg[PIPE_LAT-1].valid;
    assign out_last  = tag_sr_reg[PIPE_LAT-1].valid & tag_sr_reg[PIPE_LAT-1].last;
    assign done      = out_last;

endmodule

// File: tb/tb_twiddle_sched.sv
// Randomized bench for twiddle_sched against a cycle-indexed expectation model.
// Build with TWSCHED_IFFT_EN defined to exercise the conjugate-address passes.
module tb_twiddle_sched;

    localparam int N    = 256;
    localparam int LAT  = 4;
    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  stage;
    logic        inv;
    logic        busy, done, err;
    logic        in_valid;
    logic [21:0] in_data;
    logic [7:0]  tw_addr;
    logic [21:0] tw_a;
    logic        out_valid, out_last;

    always #5 clk = ~clk;

    twiddle_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
`ifdef TWSCHED_IFFT_EN
        .inv       (inv),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .tw_addr   (tw_addr),
        .tw_a      (tw_a),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // expectations indexed by absolute cycle number
    bit          ov_e   [MAXC];
    bit          last_e [MAXC];
    bit          err_e  [MAXC];
    bit          busy_e [MAXC];
    bit          achk   [MAXC];
    bit          zchk   [MAXC];
    logic [7:0]  addr_e [MAXC];
    logic [21:0] data_e [MAXC];

    int mode = 0;       // 0 idle, 1 accepting, 2 waiting for last output
    int mj, ms, drain_end;
    bit minv;
    int pass_outs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int tw_ref(input int j, input int s, input bit cj);
        int l, q, m, k, e;
        l = N >> (2 * s);
        q = l / 4;
        m = (j % l) / q;
        k = j % q;
        e = ((m * k) << (2 * s)) % N;
        if (cj) e = (N - e) % N;
        return e;
    endfunction

    task automatic step(input bit r, input bit st, input int sg, input bit iv, input bit cj);
        int c;
        int nmode;
        logic [21:0] d;
        c = cyc;
        d = 22'($urandom);
        if (c + LAT + 8 >= MAXC) begin
            $display("FAIL cycle_budget cycle=%0d got=%0d expected<%0d", c, c, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rst = r; start = st; stage = sg[3:0]; in_valid = iv; in_data = d; inv = cj;
        nmode = mode;
        if (r) begin
            for (int i = 1; i <= 8; i++) begin
                ov_e[c+i] = 0; last_e[c+i] = 0; err_e[c+i] = 0; achk[c+i] = 0;
            end
            zchk[c+1] = 1;
            nmode = 0;
        end else begin
            case (mode)
                0: begin
                    if (st) begin
                        if (sg < 4) begin
                            nmode = 1; mj = 0; ms = sg;
`ifdef TWSCHED_IFFT_EN
                            minv = cj;
`else
                            minv = 0;
`endif
                        end else begin
                            err_e[c+1] = 1;
                        end
                    end
                    if (iv) err_e[c+1] = 1;
                end
                1: begin
                    if (st) err_e[c+1] = 1;
                    if (iv) begin
                        achk[c+1]   = 1;
                        addr_e[c+1] = 8'(tw_ref(mj, ms, minv));
                        data_e[c+1] = d;
                        ov_e[c+LAT] = 1;
                        if (mj == N - 1) begin
                            last_e[c+LAT] = 1;
                            drain_end     = c + LAT;
                            nmode         = 2;
                        end
                        mj++;
                    end
                end
                default: begin
                    if (st || iv) err_e[c+1] = 1;
                    if (c == drain_end) nmode = 0;
                end
            endcase
        end
        mode = nmode;
        busy_e[c+1] = (nmode != 0);

        @(posedge clk);
        #1;
        cyc++;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, ov_e[cyc]});
        check_eq("out_last",  {31'd0, out_last},  {31'd0, last_e[cyc]});
        check_eq("done",      {31'd0, done},      {31'd0, last_e[cyc]});
        check_eq("err",       {31'd0, err},       {31'd0, err_e[cyc]});
        check_eq("busy",      {31'd0, busy},      {31'd0, busy_e[cyc]});
        if (out_valid) pass_outs++;
        if (achk[cyc]) begin
            check_eq("tw_addr", {24'd0, tw_addr}, {24'd0, addr_e[cyc]});
            check_eq("tw_a",    {10'd0, tw_a},    {10'd0, data_e[cyc]});
        end
        if (zchk[cyc]) begin
            check_eq("tw_addr_rst", {24'd0, tw_addr}, 32'd0);
            check_eq("tw_a_rst",    {10'd0, tw_a},    32'd0);
        end
    endtask

    // dens < 0 selects a strict 1,0,1,0 in_valid pattern
    task automatic run_pass(input int s, input int dens, input int spur, input int rst_at, input bit cj);
        int guard;
        bit iv;
        pass_outs = 0;
        step(0, 1, s, 0, cj);
        guard = 0;
        while (mode != 0 && guard < 4000) begin
            if (rst_at >= 0 && mode == 1 && mj == rst_at) begin
                step(1, 0, 0, 0, 0);
                break;
            end
            iv = (dens < 0) ? (guard % 2 == 0) : ($urandom_range(99) < dens);
            step(0, $urandom_range(99) < spur, $urandom_range(15), iv, 1'($urandom_range(1)));
            guard++;
        end
        if (guard >= 4000) check_eq("pass_timeout", {31'd0, busy}, 32'd0);
        $display("pass stage=%0d inv=%0d accepted=%0d out_valid_pulses=%0d end_cycle=%0d",
                 s, cj, mj, pass_outs, cyc);
    endtask

    task automatic idle(input int n, input bit bad);
        for (int i = 0; i < n; i++) begin
            step(0, bad && ($urandom_range(3) == 0), $urandom_range(4, 15),
                 bad && ($urandom_range(2) == 0), 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; stage = 0; in_valid = 0; in_data = 0; inv = 0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        idle(6, 0);
        idle(24, 1);
        run_pass(0, 100, 0, -1, 0);
        idle(3, 0);
        run_pass(0, -1, 0, -1, 0);
        idle(5, 1);
        run_pass(1, 70, 0, -1, 0);
        run_pass(3, 80, 0, -1, 0);
        run_pass(2, 60, 3, -1, 0);
        idle(8, 1);
        run_pass(0, 90, 4, -1, 0);
        run_pass($urandom_range(3), 100, 0, 100, 0);
        idle(2, 0);
        run_pass(1, 100, 0, -1, 0);
`ifdef TWSCHED_IFFT_EN
        run_pass(0, 100, 0, -1, 1);
        run_pass(1, 75, 2, -1, 1);
`endif
        idle(10, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
